axi_mem_responder: RTL and testbench

AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

---
 rtl/axi_pkg.sv | 19 +
 rtl/mem_array.sv | 50 +++++
 rtl/axi_mem_responder.sv | 225 ++++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// ----------------------------------------------------------------------------
// axi_pkg
// Shared AXI response codes and the responder FSM state encoding.
// ----------------------------------------------------------------------------
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StWrCollect,
        StWrLat,
        StWrResp,
        StRdLat,
        StRdResp
    } state_t;

endpackage

// File: rtl/mem_array.sv
// ----------------------------------------------------------------------------
// mem_array
// DEPTH x DATA_W line storage with a synchronous write port and a registered
// read port. The array itself is not reset; only the read register is.
//
// Ports
//   clk    rising-edge clock
//   rst    asynchronous active-low reset (read register only)
//   we     write strobe, writes wdata to line waddr
//   waddr  write line index
//   wdata  write line data
//   re     read strobe, loads line raddr into the read register
//   raddr  read line index
//   rdata  registered read data
// ----------------------------------------------------------------------------
module mem_array #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned DEPTH  = 256,
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/axi_mem_responder.sv
// ----------------------------------------------------------------------------
// axi_mem_responder
// Single-outstanding AXI-style memory responder with fixed access latency.
// One line (DATA_W bits) per beat; writes take priority over reads in IDLE.
// Addresses at or above DEPTH lines answer SLVERR, skip the write and read 0.
//
// Ports
//   clk, rst                          clock, asynchronous active-low reset
//   araddr/arvalid/arready            read-address channel
//   rdata/rresp/rvalid/rready         read-data channel
//   awaddr/awvalid/awready            write-address channel
//   wdata/wvalid/wready               write-data channel
//   bresp/bvalid/bready               write-response channel
// ----------------------------------------------------------------------------
module axi_mem_responder
    import axi_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned LAT    = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,

    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready,

    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,

    input  logic [DATA_W-1:0] wdata,
    input  logic              wvalid,
    output logic              wready,

    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready
);

    localparam int unsigned OFF_W      = $clog2(DATA_W / 8);
    localparam int unsigned IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [63:0] ADDR_LIMIT = 64'(DEPTH) * 64'(DATA_W / 8);
    localparam logic [3:0]  LAT_LOAD   = 4'(LAT - 1);
    // With LAT=1 the response is due the cycle right after the handshake, so
    // the latency state is skipped and the access commits on the handshake edge.
    localparam state_t WR_TARGET = (LAT == 1) ? StWrResp : StWrLat;
    localparam state_t RD_TARGET = (LAT == 1) ? StRdResp : StRdLat;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              have_aw_q, have_aw_d;
    logic [1:0]        resp_q, resp_d;

    logic              addr_err;
    logic              wr_commit;
    logic              rd_commit;
    logic              mem_we;
    logic [IDX_W-1:0]  line_idx;
    logic [DATA_W-1:0] mem_rdata;

    // ------------------------------------------------------------------------
    // FSM next-state and ready outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        have_aw_d = have_aw_q;
        awready   = 1'b0;
        wready    = 1'b0;
        arready   = 1'b0;

        unique case (state_q)
            StIdle: begin
                awready = 1'b1;
                wready  = 1'b1;
                // Any write activity blocks AR so the write is served first.
                arready = !awvalid && !wvalid;
                if (awvalid && wvalid) begin
                    addr_d  = awaddr;
                    data_d  = wdata;
                    cnt_d   = LAT_LOAD;
                    state_d = WR_TARGET;
                end else if (awvalid) begin
                    addr_d    = awaddr;
                    have_aw_d = 1'b1;
                    state_d   = StWrCollect;
                end else if (wvalid) begin
                    data_d    = wdata;
                    have_aw_d = 1'b0;
                    state_d   = StWrCollect;
                end else if (arvalid) begin
                    addr_d  = araddr;
                    cnt_d   = LAT_LOAD;
                    state_d = RD_TARGET;
                end
            end

            StWrCollect: begin
                awready = !have_aw_q;
                wready  = have_aw_q;
                if (have_aw_q && wvalid) begin
                    data_d  = wdata;
                    cnt_d   = LAT_LOAD;
                    state_d = WR_TARGET;
                end else if (!have_aw_q && awvalid) begin
                    addr_d  = awaddr;
                    cnt_d   = LAT_LOAD;
                    state_d = WR_TARGET;
                end
            end

            // Counter is loaded with LAT-1 on the handshake edge and reaches 0
            // on the exit edge, so valid rises LAT cycles after the handshake.
            StWrLat: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = StWrResp;
                end
            end

            StRdLat: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = StRdResp;
                end
            end

            StWrResp: begin
                if (bready) begin
                    state_d = StIdle;
                end
            end

            StRdResp: begin
                if (rready) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Commit decode: the access happens on the edge that enters a RESP state,
    // using the address/data the capture registers are about to hold.
    // ------------------------------------------------------------------------
    assign addr_err  = 64'(addr_d) >= ADDR_LIMIT;
    assign wr_commit = (state_d == StWrResp) && (state_q != StWrResp);
    assign rd_commit = (state_d == StRdResp) && (state_q != StRdResp);
    assign line_idx  = addr_d[OFF_W +: IDX_W];
    // Reset gating keeps an aborted transaction from writing on a clock edge
    // that lands while rst is still low.
    assign mem_we    = wr_commit && !addr_err && rst;

    always_comb begin
        resp_d = resp_q;
        if (wr_commit || rd_commit) begin
            resp_d = addr_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            have_aw_q <= 1'b0;
            resp_q    <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            have_aw_q <= have_aw_d;
            resp_q    <= resp_d;
        end
    end

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem_array (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (line_idx),
        .wdata (data_d),
        .re    (rd_commit),
        .raddr (line_idx),
        .rdata (mem_rdata)
    );

    // ------------------------------------------------------------------------
    // Response outputs
    // ------------------------------------------------------------------------
    assign bvalid = (state_q == StWrResp);
    assign rvalid = (state_q == StRdResp);
    assign bresp  = bvalid ? resp_q : RESP_OKAY;
    assign rresp  = rvalid ? resp_q : RESP_OKAY;
    // An out-of-range read still strobes the array; its line is masked here.
    assign rdata  = (rresp == RESP_SLVERR) ? '0 : mem_rdata;

endmodule

// File: tb/tb_axi_mem_responder.sv
module tb_axi_mem_responder;

    localparam int LAT = 4;

    logic         clk;
    logic         rst;
    logic [31:0]  araddr;
    logic         arvalid;
    logic         arready;
    logic [127:0] rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [31:0]  awaddr;
    logic         awvalid;
    logic         awready;
    logic [127:0] wdata;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;

    axi_mem_responder #(
        .ADDR_W (32),
        .DATA_W (128),
        .DEPTH  (256),
        .LAT    (LAT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit           is_rd;
        logic [1:0]   resp;
        logic [127:0] data;
        int           exp_cyc;
    } exp_t;

    exp_t         sb[$];
    logic [127:0] model_mem [int];

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 4) & 32'h0000_00FF);
    endfunction

    function automatic bit addr_bad(input logic [31:0] a);
        return a >= 32'h0000_1000;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [127:0] d, input int hs);
        exp_t e;
        e.is_rd   = 1'b0;
        e.resp    = addr_bad(a) ? 2'b10 : 2'b00;
        e.data    = '0;
        e.exp_cyc = hs + LAT;
        sb.push_back(e);
        if (!addr_bad(a)) model_mem[line_of(a)] = d;
    endtask

    task automatic push_rd(input logic [31:0] a, input int hs);
        exp_t e;
        e.is_rd   = 1'b1;
        e.exp_cyc = hs + LAT;
        if (addr_bad(a)) begin
            e.resp = 2'b10;
            e.data = '0;
        end else begin
            e.resp = 2'b00;
            e.data = model_mem.exists(line_of(a)) ? model_mem[line_of(a)] : '0;
        end
        sb.push_back(e);
    endtask

    // Monitor: pops the scoreboard on every response handshake.
    bit   b_prev = 1'b0;
    bit   r_prev = 1'b0;
    int   b_rise = 0;
    int   r_rise = 0;
    exp_t mon_e;

    initial begin
        forever begin
            @(negedge clk);
            if (bvalid && !b_prev) b_rise = cyc;
            if (rvalid && !r_prev) r_rise = cyc;
            b_prev = bvalid;
            r_prev = rvalid;
            if (bvalid && bready) begin
                if (sb.size() == 0 || sb[0].is_rd) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL b_unexpected: got bresp %b, expected no write response", bresp);
                end else begin
                    mon_e = sb.pop_front();
                    chk("bresp", 128'(bresp), 128'(mon_e.resp));
                    chk("b_latency", 128'(b_rise), 128'(mon_e.exp_cyc));
                end
            end
            if (rvalid && rready) begin
                if (sb.size() == 0 || !sb[0].is_rd) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL r_unexpected: got rresp %b, expected no read response", rresp);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rresp", 128'(rresp), 128'(mon_e.resp));
                    chk("rdata", rdata, mon_e.data);
                    chk("r_latency", 128'(r_rise), 128'(mon_e.exp_cyc));
                end
            end
        end
    end

    task automatic wait_b();
        bit done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bvalid && bready) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) timeout("wait_b");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_r();
        bit done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rvalid && rready) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) timeout("wait_r");
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [127:0] d);
        bit found = 1'b0;
        awaddr  = a;
        wdata   = d;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (awready && wready) begin
                push_wr(a, d, cyc);
                found = 1'b1;
                break;
            end
        end
        if (!found) timeout("aw_w_handshake");
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (found) wait_b();
    endtask

    task automatic do_read(input logic [31:0] a);
        bit found = 1'b0;
        araddr  = a;
        arvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (arready) begin
                push_rd(a, cyc);
                found = 1'b1;
                break;
            end
        end
        if (!found) timeout("ar_handshake");
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        if (found) wait_r();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit   found;
        bit   b_done;
        int   c0;
        logic [127:0] d3;

        rst     = 1'b0;
        arvalid = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        araddr  = '0;
        awaddr  = '0;
        wdata   = '0;
        bready  = 1'b1;
        rready  = 1'b1;

        // Reset state
        #3;
        chk("rst_bvalid", 128'(bvalid), 128'(0));
        chk("rst_rvalid", 128'(rvalid), 128'(0));
        chk("rst_rdata", rdata, 128'(0));
        chk("rst_rresp", 128'(rresp), 128'(0));
        chk("rst_bresp", 128'(bresp), 128'(0));
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("post_rst_arready", 128'(arready), 128'(1));
        chk("post_rst_awready", 128'(awready), 128'(1));
        chk("post_rst_wready", 128'(wready), 128'(1));
        @(posedge clk);
        #1;

        // Basic write then read of line 0x40
        do_write(32'h0000_0040, {16{8'hA5}});
        do_read(32'h0000_0040);

        // AW first, W three cycles later
        d3 = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
        c0 = cyc;
        awaddr  = 32'h0000_0080;
        awvalid = 1'b1;
        @(negedge clk);
        chk("split_aw_ready", 128'(awready), 128'(1));
        @(posedge clk);
        #1 awvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("split_wready_hi", 128'(wready), 128'(1));
            chk("split_awready_lo", 128'(awready), 128'(0));
            @(posedge clk);
            #1;
        end
        wdata  = d3;
        wvalid = 1'b1;
        @(negedge clk);
        chk("split_wready_c3", 128'(wready), 128'(1));
        chk("split_awready_c3", 128'(awready), 128'(0));
        chk("split_w_cycle", 128'(cyc - c0), 128'(3));
        if (wready) push_wr(32'h0000_0080, d3, cyc);
        @(posedge clk);
        #1 wvalid = 1'b0;
        @(negedge clk);
        chk("split_wready_off", 128'(wready), 128'(0));
        wait_b();

        // Simultaneous AR and AW+W to the same line: write wins
        araddr  = 32'h0000_0040;
        arvalid = 1'b1;
        awaddr  = 32'h0000_0040;
        wdata   = {16{8'h5A}};
        awvalid = 1'b1;
        wvalid  = 1'b1;
        @(negedge clk);
        chk("prio_awready", 128'(awready), 128'(1));
        chk("prio_arready", 128'(arready), 128'(0));
        if (awready && wready) push_wr(32'h0000_0040, {16{8'h5A}}, cyc);
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        b_done  = 1'b0;
        found   = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!b_done) begin
                chk("prio_arready_held", 128'(arready), 128'(0));
                if (bvalid && bready) b_done = 1'b1;
            end else begin
                chk("prio_arready_after_b", 128'(arready), 128'(1));
                if (arready) push_rd(32'h0000_0040, cyc);
                found = 1'b1;
                break;
            end
        end
        if (!found) timeout("prio_read_start");
        @(posedge clk);
        #1 arvalid = 1'b0;
        wait_r();

        // Read with rready held low for 5 cycles
        rready  = 1'b0;
        araddr  = 32'h0000_0080;
        arvalid = 1'b1;
        found   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (arready) begin
                push_rd(32'h0000_0080, cyc);
                found = 1'b1;
                break;
            end
        end
        if (!found) timeout("hold_ar_handshake");
        @(posedge clk);
        #1 arvalid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rvalid) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            timeout("hold_rvalid_rise");
        end else begin
            for (int k = 0; k < 5; k++) begin
                if (k > 0) @(negedge clk);
                chk("hold_rvalid", 128'(rvalid), 128'(1));
                chk("hold_rdata", rdata, d3);
            end
            @(posedge clk);
            #1 rready = 1'b1;
            @(negedge clk);
            chk("hold_release_rvalid", 128'(rvalid), 128'(1));
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("hold_rvalid_drop", 128'(rvalid), 128'(0));
            @(posedge clk);
            #1;
        end
        rready = 1'b1;

        // Out-of-range accesses: line 0 aliases 0x1000 and must stay intact
        do_write(32'h0000_0000, 128'h01234567_89ABCDEF_FEDCBA98_76543210);
        do_write(32'h0000_1000, {16{8'hFF}});
        do_read(32'h0000_0000);
        do_read(32'h0000_1000);
        // Offset bits ignored
        do_read(32'h0000_004C);

        // Reset during the second WR_LAT cycle aborts the write
        awaddr  = 32'h0000_0040;
        wdata   = {16{8'h77}};
        awvalid = 1'b1;
        wvalid  = 1'b1;
        @(negedge clk);
        chk("abort_aw_ready", 128'(awready), 128'(1));
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_bvalid", 128'(bvalid), 128'(0));
        chk("abort_rdata", rdata, 128'(0));
        chk("abort_bresp", 128'(bresp), 128'(0));
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("abort_awready", 128'(awready), 128'(1));
        chk("abort_wready", 128'(wready), 128'(1));
        chk("abort_arready", 128'(arready), 128'(1));
        @(posedge clk);
        #1;
        do_read(32'h0000_0040);

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", 128'(sb.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
